// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

    localparam int DEF_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rbs_sub.sv
// Ripple-borrow subtractor d = x - y, one generated borrow cell per bit.
module rbs_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] bw;

    assign bw[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_cell
        // Full-subtractor cell: borrow out when x < y + borrow-in at this bit.
        assign d[i]    = x[i] ^ y[i] ^ bw[i];
        assign bw[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw[i]);
    end

    assign bout = bw[W];

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider, one quotient bit per clock behind start/done.
// Optional macro SEQ_DIV_SIGNED_EN switches operands and results to two's complement.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dz
);

    localparam int CW = $clog2(N);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N:0]    pr;
    logic [N-1:0]  qs;
    logic [N-1:0]  bl;

    logic [N-1:0]  am;
    logic [N-1:0]  bm;
    logic [N:0]    sh;
    logic [N:0]    diff;
    logic          bw;
    logic [N:0]    pr_next;
    logic [N-1:0]  qs_next;
    logic [N-1:0]  qf;
    logic [N-1:0]  rf;

`ifdef SEQ_DIV_SIGNED_EN
    logic          sq;
    logic          sr;

    // Magnitudes feed the unsigned core; -2^(N-1) maps to 2^(N-1) unsigned.
    assign am = a[N-1] ? N'(~a + 1'b1) : a;
    assign bm = b[N-1] ? N'(~b + 1'b1) : b;
    assign qf = sq ? N'(~qs_next + 1'b1) : qs_next;
    assign rf = sr ? N'(~pr_next[N-1:0] + 1'b1) : pr_next[N-1:0];
`else
    assign am = a;
    assign bm = b;
    assign qf = qs_next;
    assign rf = pr_next[N-1:0];
`endif

    // Top remainder bit is always zero between steps, so it drops out of the shift.
    assign sh = (N+1)'({pr, qs[N-1]});

    rbs_sub #(.W(N+1)) u_sub (
        .x    (sh),
        .y    ({1'b0, bl}),
        .d    (diff),
        .bout (bw)
    );

    assign pr_next = bw ? sh : diff;
    assign qs_next = {qs[N-2:0], ~bw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pr    <= '0;
            qs    <= '0;
            bl    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            sq    <= 1'b0;
            sr    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bl <= bm;
`ifdef SEQ_DIV_SIGNED_EN
                        sq <= a[N-1] ^ b[N-1];
                        sr <= a[N-1];
`endif
                        if (b == '0) begin
                            q     <= '1;
                            r     <= a;
                            dz    <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pr    <= '0;
                            qs    <= am;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    pr  <= pr_next;
                    qs  <= qs_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N-1)) begin
                        q     <= qf;
                        r     <= rf;
                        dz    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
Multi-cycle restoring divider; the inverse counterpart of the team's ripple-carry adder.
- Computes quotient and remainder of two N-bit operands by repeated trial subtraction, one quotient bit per clock.
- Sits beside the adder/subtractor units in the ALU datapath, behind a start/done handshake.
- Built on a ripple-borrow subtractor cell chain, the mirror of the ripple-carry adder cell chain.

Parameters:
N, 4, operand, quotient and remainder width in bits (N >= 2).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a division; honoured only in IDLE
a  input  N  dividend, sampled on the accepting edge
b  input  N  divisor, sampled on the accepting edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: q, r and dz are valid
q  output  N  quotient, registered
r  output  N  remainder, registered
dz  output  1  divide-by-zero flag for the last result

Behaviour:
- Reset: asynchronous, active-low, one clock domain. While rst_n=0: state=IDLE, busy=0, done=0, dz=0, q=0, r=0, iteration counter=0. Reset asserted mid-RUN aborts the operation with no partial result.
- States: IDLE, RUN, DONE.
- IDLE with start=1 on edge E0:
  - a and b are latched.
  - If b != 0: partial remainder (N+1 bits) = 0, quotient shift register = a, counter = 0, next state RUN.
  - If b == 0: next state DONE; q = all ones, r = a, dz = 1 on E0; done=1 during the following cycle.
- RUN, on each edge E1..EN:
  - Shift {partial remainder, quotient} left by one.
  - Trial-subtract the zero-extended b from the partial remainder.
  - No borrow: keep the difference and set quotient LSB = 1. Borrow: keep the shifted value and set LSB = 0.
  - Counter increments each edge. At EN (counter = N-1): write q and r (low N bits), dz=0, next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge. start in DONE is ignored.
- Latency: done is high in the cycle after edge EN, i.e. N edges after the accepting edge. Divide-by-zero: 1 edge.
- busy=1 exactly in RUN. start in RUN is ignored, and a/b changes in RUN have no effect.
- q, r and dz hold their last values from DONE until the next accepted start completes; they are not cleared on accept.
- Arithmetic (unsigned):
  - Partial remainder is N+1 bits; the subtractor is N+1 bits wide, so the shifted remainder never overflows.
  - Always q*b + r == a and r < b (b != 0).

Optional Feature:
SEQ_DIV_SIGNED_EN
- Defined: a, b, q and r are two's complement.
  - Magnitudes are taken at the accepting edge and the unsigned core runs unchanged.
  - At EN, q is negated when sign(a) != sign(b), and r is negated when a < 0. Quotient truncates toward zero; r takes the sign of a.
  - -2^(N-1) / -1 wraps: q = -2^(N-1), r = 0.
  - Divide by zero: q = -1 (all ones), r = a, dz = 1.
  - Latency is identical.
- Undefined: purely unsigned behaviour as above; no sign logic is synthesised.

Decomposition:
- Package seq_div_pkg: state enum typedef (IDLE, RUN, DONE) and the default width constant.
- Sub-module rbs_sub: parameterised ripple-borrow subtractor.
  - Inputs x, y; outputs d and bout.
  - Generated per-bit borrow cells, mirroring the adder's per-bit cells.
  - Instantiated at width N+1 in seq_div.
- Counter width is derived from N: $clog2(N).

Test Plan:
- N=4, a=13, b=3, start pulse -> busy high for 4 cycles, done 4 edges after accept, q=4, r=1, dz=0.
- a=5, b=0 -> done 1 edge after accept, busy never high, q=15, r=5, dz=1.
- Edge operands:
  - a=2, b=7 -> q=0, r=2.
  - a=15, b=1 -> q=15, r=0.
  - a=15, b=15 -> q=1, r=0.
- Accept a=13, b=3; pulse start with a=9, b=2 during RUN -> ignored, result q=4, r=1; a new start in IDLE afterwards yields q=4, r=1 for 9/2.
- rst_n low after edge E2 of a 13/3 run -> q=0, r=0, busy=0, done=0 immediately without a clock; after release a new 6/4 gives q=1, r=2.
- SEQ_DIV_SIGNED_EN:
  - a=4'b1001 (-7), b=2 -> q=4'b1101 (-3), r=4'b1111 (-1).
  - a=4'b1000, b=4'b1111 -> q=4'b1000, r=0.
  - Without the macro, a=9, b=2 -> q=4, r=1.
